// File: rtl/prog_loader.sv
// Program loader: parses a framed byte stream and writes 18-bit instructions into the
// writable program memory, holding the MCU in reset until a load is verified.
module prog_loader #(
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] SYNC_BYTE   = 8'h5A,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              PROG_WE,
    output logic [ADDR_W-1:0] PROG_WADDR,
    output logic [17:0]       PROG_WDATA,
    output logic              MCU_RST,
    output logic              LOADING,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_HI = 3'd1;
    localparam logic [2:0] S_CNT_LO = 3'd2;
    localparam logic [2:0] S_B0     = 3'd3;
    localparam logic [2:0] S_B1     = 3'd4;
    localparam logic [2:0] S_B2     = 3'd5;
    localparam logic [2:0] S_CHK    = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam int          TMR_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned MAX_WORDS = 1 << ADDR_W;

    logic [2:0]        state;
    logic [7:0]        cnt_hi;
    logic [ADDR_W:0]   words_left;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        sum;
    logic [1:0]        b0_bits;
    logic [7:0]        b1_byte;
    logic [TMR_W-1:0]  timer;

    logic [15:0] cnt_full;
    logic        cnt_ok;
    logic        in_packet;
    logic        timed_out;

    always_comb begin
        cnt_full  = {cnt_hi, RX_DATA};
        cnt_ok    = (cnt_full != 16'd0) && (32'(cnt_full) <= MAX_WORDS);
        in_packet = (state != S_IDLE) && (state != S_ERR);
        timed_out = in_packet && !RX_VALID && (timer == TMR_W'(TIMEOUT_CYC - 1));
    end

    // NOTE: every register sits in one clocked block with non-blocking assignments and
    // a synchronous reset, so a reset cycle also suppresses any write in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            cnt_hi     <= '0;
            words_left <= '0;
            addr       <= '0;
            sum        <= '0;
            b0_bits    <= '0;
            b1_byte    <= '0;
            timer      <= '0;
            PROG_WE    <= 1'b0;
            PROG_WADDR <= '0;
            PROG_WDATA <= '0;
            MCU_RST    <= 1'b0;
            LOADING    <= 1'b0;
            LOAD_DONE  <= 1'b0;
            LOAD_ERR   <= 1'b0;
        end else begin
            PROG_WE   <= 1'b0;
            LOAD_DONE <= 1'b0;

            // Inter-byte watchdog runs only while a packet is being parsed.
            if (RX_VALID || !in_packet) begin
                timer <= '0;
            end else if (!timed_out) begin
                timer <= timer + TMR_W'(1);
            end

            if (timed_out) begin
                state    <= S_ERR;
                LOAD_ERR <= 1'b1;
                LOADING  <= 1'b0;
            end else if (RX_VALID) begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (RX_DATA == SYNC_BYTE) begin
                            state    <= S_CNT_HI;
                            LOADING  <= 1'b1;
                            MCU_RST  <= 1'b1;
                            LOAD_ERR <= 1'b0;
                            addr     <= '0;
                            sum      <= '0;
                        end
                    end
                    S_CNT_HI: begin
                        cnt_hi <= RX_DATA;
                        state  <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        if (cnt_ok) begin
                            words_left <= cnt_full[ADDR_W:0];
                            state      <= S_B0;
                        end else begin
                            state    <= S_ERR;
                            LOAD_ERR <= 1'b1;
                            LOADING  <= 1'b0;
                        end
                    end
                    S_B0: begin
                        b0_bits <= RX_DATA[1:0];
                        sum     <= sum + RX_DATA;
                        state   <= S_B1;
                    end
                    S_B1: begin
                        b1_byte <= RX_DATA;
                        sum     <= sum + RX_DATA;
                        state   <= S_B2;
                    end
                    S_B2: begin
                        sum        <= sum + RX_DATA;
                        PROG_WE    <= 1'b1;
                        PROG_WADDR <= addr;
                        PROG_WDATA <= {b0_bits, b1_byte, RX_DATA};
                        // A full-size load wraps addr back to 0; the word count ends it.
                        addr       <= addr + ADDR_W'(1);
                        words_left <= words_left - (ADDR_W + 1)'(1);
                        state      <= (words_left == (ADDR_W + 1)'(1)) ? S_CHK : S_B0;
                    end
                    S_CHK: begin
                        LOADING <= 1'b0;
                        if (RX_DATA == sum) begin
                            state     <= S_IDLE;
                            LOAD_DONE <= 1'b1;
                            MCU_RST   <= 1'b0;
                        end else begin
                            state    <= S_ERR;
                            LOAD_ERR <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
